// File: rtl/opnd_mem_seq_pkg.sv
// Shared encodings for the operand memory sequencer: FSM states, error bit
// positions and request direction.
package opnd_mem_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_REQ    = 3'd1,
    SEQ_RSP    = 3'd2,
    SEQ_OPND   = 3'd3,
    SEQ_WBWAIT = 3'd4,
    SEQ_FIN    = 3'd5
  } seq_state_t;

  localparam int ERR_MISMATCH = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_TIMEOUT  = 2;

  localparam logic MEM_RW_WRITE = 1'b1;

  // Access index saturates at 2: slot 2 means "beyond the two hints".
  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd2 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/opnd_mem_seq_if.sv
// Single memory port used by the sequencer: one request channel and one
// response strobe.
interface opnd_mem_seq_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Request transfers on a cycle where mem_req_valid && mem_req_ready; the
  // master holds rw/addr/wdata stable and valid high until then. The response
  // is a single-cycle mem_rsp_valid strobe with no back-pressure.
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/opnd_mem_seq_hint_check.sv
// Compares one memory access against the hint slot selected by its issue
// index; index 2 and above has no hint and flags overflow instead.
module opnd_mem_seq_hint_check #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [1:0]    idx,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          data_en,
  input  logic          hint1_rw,
  input  logic [AW-1:0] hint1_address,
  input  logic [DW-1:0] hint1_data,
  input  logic          hint2_rw,
  input  logic [AW-1:0] hint2_address,
  input  logic [DW-1:0] hint2_data,
  output logic          mismatch,
  output logic          overflow
);

  logic          sel_rw;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign sel_rw   = (idx == 2'd0) ? hint1_rw      : hint2_rw;
  assign sel_addr = (idx == 2'd0) ? hint1_address : hint2_address;
  assign sel_data = (idx == 2'd0) ? hint1_data    : hint2_data;

  assign overflow = (idx >= 2'd2);
  assign mismatch = !overflow &&
                    ((rw != sel_rw) || (addr != sel_addr) ||
                     (data_en && (data != sel_data)));

endmodule

// File: rtl/opnd_mem_seq.sv
// Issues the operand reads and optional destination write of one decoded step
// over a single memory port, one access at a time, checking each against hints.
module opnd_mem_seq
  import opnd_mem_seq_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rd0_en,
  input  logic [AW-1:0] rd0_addr,
  input  logic          rd1_en,
  input  logic [AW-1:0] rd1_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wb_valid,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          hint1_rw,
  input  logic [AW-1:0] hint1_address,
  input  logic [DW-1:0] hint1_data,
  input  logic          hint2_rw,
  input  logic [AW-1:0] hint2_address,
  input  logic [DW-1:0] hint2_data,
  opnd_mem_seq_if.master mem,
  output logic [DW-1:0] opnd0_mem,
  output logic [DW-1:0] opnd1_mem,
  output logic          opnds_valid,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err,
  output seq_state_t    state
);

  localparam int CW = $clog2(TMO + 1);

  seq_state_t    state_q, state_d;
  logic          rd1_en_q, wr_en_q;
  logic [AW-1:0] rd1_addr_q, wr_addr_q;
  logic          req_rw_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_wdata_q;
  logic          rd_sel_q, rd_sel_d;
  logic [1:0]    idx_q;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    err_q;
  logic [DW-1:0] opnd0_q, opnd1_q;
  logic          ovalid_q;

  logic          req_load, req_wr;
  logic [AW-1:0] req_addr_d;
  logic          hs, rsp, tmo;
  logic          in_rsp, chk_en, mismatch, overflow;
  logic [DW-1:0] chk_data;

  // Handshake checks rw/addr (and wdata for writes); a read's data is only
  // known when its response arrives, so it is checked again then.
  assign in_rsp   = (state_q == SEQ_RSP);
  assign chk_data = in_rsp ? mem.mem_rsp_data : req_wdata_q;
  assign chk_en   = in_rsp ? (req_rw_q != MEM_RW_WRITE) : (req_rw_q == MEM_RW_WRITE);

  opnd_mem_seq_hint_check #(.AW(AW), .DW(DW)) u_hint_check (
    .idx           (idx_q),
    .rw            (req_rw_q),
    .addr          (req_addr_q),
    .data          (chk_data),
    .data_en       (chk_en),
    .hint1_rw      (hint1_rw),
    .hint1_address (hint1_address),
    .hint1_data    (hint1_data),
    .hint2_rw      (hint2_rw),
    .hint2_address (hint2_address),
    .hint2_data    (hint2_data),
    .mismatch      (mismatch),
    .overflow      (overflow)
  );

  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    req_load   = 1'b0;
    req_wr     = 1'b0;
    req_addr_d = '0;
    hs         = 1'b0;
    rsp        = 1'b0;
    tmo        = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          if (rd0_en) begin
            state_d = SEQ_REQ; req_load = 1'b1; req_addr_d = rd0_addr; rd_sel_d = 1'b0;
          end else if (rd1_en) begin
            state_d = SEQ_REQ; req_load = 1'b1; req_addr_d = rd1_addr; rd_sel_d = 1'b1;
          end else begin
            state_d = SEQ_OPND;
          end
        end
      end
      SEQ_REQ: begin
        if (mem.mem_req_ready) begin
          hs      = 1'b1;
          state_d = SEQ_RSP;
        end
      end
      SEQ_RSP: begin
        if (mem.mem_rsp_valid) begin
          rsp = 1'b1;
          if (req_rw_q == MEM_RW_WRITE) begin
            state_d = SEQ_FIN;
          end else if (!rd_sel_q && rd1_en_q) begin
            state_d = SEQ_REQ; req_load = 1'b1; req_addr_d = rd1_addr_q; rd_sel_d = 1'b1;
          end else begin
            state_d = SEQ_OPND;
          end
        end else if (tmo_cnt == CW'(TMO - 1)) begin
          tmo     = 1'b1;
          state_d = SEQ_FIN;
        end
      end
      SEQ_OPND:   state_d = wr_en_q ? SEQ_WBWAIT : SEQ_FIN;
      SEQ_WBWAIT: begin
        if (wb_valid) begin
          state_d = SEQ_REQ; req_load = 1'b1; req_wr = 1'b1; req_addr_d = wr_addr_q;
        end
      end
      SEQ_FIN:    state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      rd1_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      rd1_addr_q  <= '0;
      wr_addr_q   <= '0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rd_sel_q    <= 1'b0;
      idx_q       <= 2'd0;
      tmo_cnt     <= '0;
      err_q       <= '0;
      opnd0_q     <= '0;
      opnd1_q     <= '0;
      ovalid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_sel_q <= rd_sel_d;
      if (state_q == SEQ_IDLE && start) begin
        rd1_en_q   <= rd1_en;
        rd1_addr_q <= rd1_addr;
        wr_en_q    <= wr_en;
        wr_addr_q  <= wr_addr;
        err_q      <= '0;
        idx_q      <= 2'd0;
        opnd0_q    <= '0;
        opnd1_q    <= '0;
      end
      if (req_load) begin
        req_rw_q   <= req_wr;
        req_addr_q <= req_addr_d;
        if (req_wr) req_wdata_q <= wb_data;
      end
      if (hs) begin
        tmo_cnt <= '0;
        if (mismatch) err_q[ERR_MISMATCH] <= 1'b1;
        if (overflow) err_q[ERR_OVERFLOW] <= 1'b1;
      end else if (in_rsp && !rsp) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (tmo) err_q[ERR_TIMEOUT] <= 1'b1;
      // The index advances on response so the read-data check sees the same slot.
      if (rsp) begin
        if (req_rw_q != MEM_RW_WRITE) begin
          if (rd_sel_q) opnd1_q <= mem.mem_rsp_data;
          else          opnd0_q <= mem.mem_rsp_data;
          if (mismatch) err_q[ERR_MISMATCH] <= 1'b1;
        end
        idx_q <= idx_next(idx_q);
      end
      if (state_q == SEQ_FIN)       ovalid_q <= 1'b0;
      else if (state_d == SEQ_OPND) ovalid_q <= 1'b1;
    end
  end

  assign mem.mem_req_valid = (state_q == SEQ_REQ);
  assign mem.mem_req_rw    = req_rw_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign wb_ready          = (state_q == SEQ_WBWAIT);
  assign busy              = (state_q != SEQ_IDLE);
  assign done              = (state_q == SEQ_FIN);
  assign opnds_valid       = ovalid_q;
  assign opnd0_mem         = opnd0_q;
  assign opnd1_mem         = opnd1_q;
  assign err               = err_q;
  assign state             = state_q;

endmodule

// File: tb/tb_opnd_mem_seq.sv
// Bench for opnd_mem_seq: directed steps then random steps, each checked
// against an access-list model of the step and a request scoreboard.
module tb_opnd_mem_seq;
  import opnd_mem_seq_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 64;
  localparam int W   = 1 + AW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, rd0_en, rd1_en, wr_en, wb_valid, wb_ready;
  logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
  logic [DW-1:0] wb_data, opnd0_mem, opnd1_mem;
  logic          hint1_rw, hint2_rw;
  logic [AW-1:0] hint1_address, hint2_address;
  logic [DW-1:0] hint1_data, hint2_data;
  logic          opnds_valid, busy, done;
  logic [2:0]    err;
  seq_state_t    state;

  opnd_mem_seq_if #(.AW(AW), .DW(DW)) mem_if ();

  opnd_mem_seq #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd1_en(rd1_en), .rd1_addr(rd1_addr),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
    .hint1_rw(hint1_rw), .hint1_address(hint1_address), .hint1_data(hint1_data),
    .hint2_rw(hint2_rw), .hint2_address(hint2_address), .hint2_data(hint2_data),
    .mem(mem_if),
    .opnd0_mem(opnd0_mem), .opnd1_mem(opnd1_mem), .opnds_valid(opnds_valid),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory image and responder controls
  logic [DW-1:0] mem_img [logic [AW-1:0]];
  int rdy_dly = 0, rsp_dly = 0, stray_cnt = 0, stray_done = 0;
  bit drop = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // hints: driven live from these arrays
  logic          h_rw[2];
  logic [AW-1:0] h_addr[2];
  logic [DW-1:0] h_data[2];
  assign hint1_rw = h_rw[0]; assign hint1_address = h_addr[0]; assign hint1_data = h_data[0];
  assign hint2_rw = h_rw[1]; assign hint2_address = h_addr[1]; assign hint2_data = h_data[1];

  // reference model: ordered access list of the step
  logic          a_rw[3];
  logic [AW-1:0] a_addr[3];
  logic [DW-1:0] a_data[3];
  int            a_own[3];
  int            a_n;
  logic [DW-1:0] e_op0, e_op1;
  logic [2:0]    e_err;
  logic          e_ovalid;

  task automatic build_accesses();
    a_n = 0;
    if (rd0_en) begin a_rw[a_n] = 0; a_addr[a_n] = rd0_addr; a_data[a_n] = rd_val(rd0_addr); a_own[a_n] = 0; a_n++; end
    if (rd1_en) begin a_rw[a_n] = 0; a_addr[a_n] = rd1_addr; a_data[a_n] = rd_val(rd1_addr); a_own[a_n] = 1; a_n++; end
    if (wr_en)  begin a_rw[a_n] = 1; a_addr[a_n] = wr_addr;  a_data[a_n] = wb_data;          a_own[a_n] = 2; a_n++; end
  endtask

  task automatic match_hints();
    for (int k = 0; k < 2; k++) begin
      if (k < a_n) begin h_rw[k] = a_rw[k]; h_addr[k] = a_addr[k]; h_data[k] = a_data[k]; end
      else begin h_rw[k] = 0; h_addr[k] = '0; h_data[k] = '0; end
    end
  endtask

  task automatic build_expect();
    e_err = '0; e_op0 = '0; e_op1 = '0; e_ovalid = 1'b1;
    exp_q.delete();
    for (int k = 0; k < a_n; k++) begin
      exp_q.push_back({a_rw[k], a_addr[k], a_rw[k] ? a_data[k] : DW'(0)});
      if (k >= 2) e_err[1] = 1'b1;
      else if (a_rw[k] !== h_rw[k] || a_addr[k] !== h_addr[k] ||
               (a_rw[k] && a_data[k] !== h_data[k])) e_err[0] = 1'b1;
      if (drop) begin
        e_err[2] = 1'b1;
        if (!a_rw[k]) e_ovalid = 1'b0;
        break;
      end
      if (!a_rw[k]) begin
        if (k < 2 && a_data[k] !== h_data[k]) e_err[0] = 1'b1;
        if (a_own[k] == 0) e_op0 = a_data[k]; else e_op1 = a_data[k];
      end
    end
  endtask

  // memory responder: delays ready, records handshakes, answers or drops
  initial begin : responder
    int ph, wcnt, rcnt;
    bit first;
    logic [W-1:0] snap, cur;
    ph = 0; wcnt = 0; rcnt = 0; first = 0; snap = '0;
    mem_if.mem_req_ready = 0; mem_if.mem_rsp_valid = 0; mem_if.mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      cur = {mem_if.mem_req_rw, mem_if.mem_req_addr, mem_if.mem_req_wdata};
      mem_if.mem_rsp_valid = 0;
      if (rst_n !== 1'b1) begin
        ph = 0; mem_if.mem_req_ready = 0;
      end else begin
        if (ph == 0 && stray_cnt != stray_done) begin
          mem_if.mem_rsp_valid = 1; mem_if.mem_rsp_data = '1; stray_done++;
        end else if (ph == 0 && mem_if.mem_req_valid === 1'b1) begin
          snap = cur; wcnt = rdy_dly; first = 1; ph = 1;
        end
        if (ph == 1) begin
          if (!first) chk("req_stable", cur, snap);
          first = 0;
          if (wcnt == 0) begin
            mem_if.mem_req_ready = 1;
            got_q.push_back(snap[W-1] ? snap : {1'b0, snap[DW +: AW], DW'(0)});
            ph = 2;
          end else wcnt--;
        end else if (ph == 2) begin
          mem_if.mem_req_ready = 0;
          if (drop) ph = 0;
          else begin rcnt = rsp_dly; ph = 3; end
        end
        if (ph == 3) begin
          if (rcnt == 0) begin
            mem_if.mem_rsp_valid = 1;
            mem_if.mem_rsp_data  = snap[W-1] ? DW'(0) : rd_val(snap[DW +: AW]);
            ph = 0;
          end else rcnt--;
        end
      end
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, " ctrl"}, {mem_if.mem_req_valid, mem_if.mem_req_rw, wb_ready, opnds_valid, busy, done, err}, '0);
    chk({tag, " req"}, {mem_if.mem_req_addr, mem_if.mem_req_wdata}, '0);
    chk({tag, " opnds"}, {opnd0_mem, opnd1_mem}, '0);
    chk({tag, " state"}, state, SEQ_IDLE);
  endtask

  // driver: one step from start pulse to return to idle
  task automatic run_step(input string tag, input int wb_wait);
    int cyc, wcnt_l;
    bit seen;
    build_expect();
    got_q.delete();
    wcnt_l = wb_wait; seen = 0; cyc = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " err_clr"}, err, 3'b000);
    while (!seen && cyc < 400) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (wb_ready === 1'b1) begin
          if (wcnt_l > 0) begin wcnt_l--; wb_valid = 0; end
          else wb_valid = 1;
        end else wb_valid = 0;
        @(negedge clk); cyc++;
      end
    end
    wb_valid = 0;
    chk({tag, " done_seen"}, seen, 1'b1);
    chk({tag, " opnd0"}, opnd0_mem, e_op0);
    chk({tag, " opnd1"}, opnd1_mem, e_op1);
    chk({tag, " err"}, err, e_err);
    chk({tag, " opnds_valid"}, opnds_valid, e_ovalid);
    if (drop && a_n > 0) chk({tag, " tmo_latency"}, (cyc >= TMO && cyc <= TMO + 4), 1'b1);
    @(negedge clk);
    chk({tag, " done_once"}, done, 1'b0);
    chk({tag, " idle"}, {busy, opnds_valid, state}, {1'b0, 1'b0, SEQ_IDLE});
    chk({tag, " err_hold"}, err, e_err);
    chk({tag, " n_req"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s req%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic cfg(input logic e0, input logic [AW-1:0] ad0, input logic e1, input logic [AW-1:0] ad1,
                     input logic ew, input logic [AW-1:0] adw, input logic [DW-1:0] wd);
    rd0_en = e0; rd0_addr = ad0; rd1_en = e1; rd1_addr = ad1; wr_en = ew; wr_addr = adw; wb_data = wd;
    build_accesses();
    match_hints();
  endtask

  initial begin : main
    int cyc;
    start = 0; wb_valid = 0; rst_n = 0;
    cfg(0, '0, 0, '0, 0, '0, '0);
    mem_img[32'h1000] = 32'hDEAD_BEEF;
    mem_img[32'h2000] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1;

    // two reads, matching hints
    cfg(1, 32'h1000, 1, 32'h2000, 0, '0, '0);
    run_step("two_reads", 0);

    // read then write, slow ready and late writeback
    rdy_dly = 4;
    cfg(1, 32'h40, 0, '0, 1, 32'h40, 32'hA5A5_A5A5);
    run_step("rd_wr", 3);
    rdy_dly = 0;

    // hint address mismatch still completes the read
    cfg(1, 32'h1000, 0, '0, 0, '0, '0);
    h_addr[0] = 32'h1004;
    run_step("mismatch", 0);

    // third access overflows the hints
    cfg(1, 32'h100, 1, 32'h104, 1, 32'h108, 32'h0BAD_F00D);
    run_step("overflow", 1);

    // no response: timeout, then a fresh step clears err
    drop = 1;
    cfg(1, 32'h200, 0, '0, 0, '0, '0);
    run_step("timeout", 0);
    drop = 0;
    cfg(0, '0, 1, 32'h2000, 0, '0, '0);
    run_step("after_tmo", 0);

    // reset during a response wait, then a stray response
    drop = 1;
    cfg(1, 32'h80, 0, '0, 0, '0, '0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    cyc = 0;
    while (state !== SEQ_RSP && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst_in_rsp", state, SEQ_RSP);
    repeat (3) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_idle_zero("rst_mid");
    rst_n = 1; drop = 0; stray_cnt++;
    repeat (3) @(negedge clk);
    chk("stray_opnd0", opnd0_mem, '0);
    chk("stray_idle", {busy, state}, {1'b0, SEQ_IDLE});

    // random steps
    for (int s = 0; s < 40; s++) begin
      rd0_en   = 1'($urandom_range(0, 1));
      rd1_en   = 1'($urandom_range(0, 1));
      wr_en    = 1'($urandom_range(0, 1));
      rd0_addr = AW'($urandom_range(0, 255) << 2);
      rd1_addr = AW'($urandom_range(0, 255) << 2);
      wr_addr  = AW'($urandom_range(0, 255) << 2);
      wb_data  = DW'($urandom);
      rdy_dly  = int'($urandom_range(0, 3));
      rsp_dly  = int'($urandom_range(0, 3));
      build_accesses();
      match_hints();
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: h_rw[k]   = ~h_rw[k];
          1: h_addr[k] = h_addr[k] ^ AW'(4);
          2: h_data[k] = h_data[k] ^ DW'(1);
          default: ;
        endcase
      end
      run_step($sformatf("rnd%0d", s), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
